dti_pr_ctrl: RTL and testbench

Parametrised per-TBU partial-reset controller. It sits between the DTI AXI-Stream ports (req_t*/rsp_t*) and the custom NoC channel (req_*/rsp_*). Each TBU can be reset on its own: open packets are closed, a DTI_TBU_CONDIS_REQ is injected, and the block waits for the ACK with a timeout. Traffic of TBUs that are not being reset keeps flowing.

---
 rtl/dti_pr_ctrl_pkg.sv | 30 +++
 rtl/dti_pr_ctrl_entry.sv | 124 ++++++++++++
 rtl/dti_pr_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dti_pr_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dti_pr_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dti_pr_ctrl_pkg : shared state encoding and DTI field helpers for dti_pr_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package dti_pr_ctrl_pkg;

    typedef enum logic [2:0] {
        PR_IDLE  = 3'd0,
        PR_CONN  = 3'd1,
        PR_TRANS = 3'd2,
        PR_FLUSH = 3'd3,
        PR_DREQ  = 3'd4,
        PR_DWAIT = 3'd5
    } pr_state_e;

    // Connect/disconnect request and ACK share the same code in opposite directions
    localparam logic [3:0] DTI_TBU_CONDIS_REQ = 4'h0;
    localparam logic [3:0] DTI_TBU_CONDIS_ACK = 4'h0;

    function automatic int msg_type_lsb(input int keep_w);
        return keep_w;
    endfunction

    function automatic int state_bit_pos(input int keep_w);
        return keep_w + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dti_pr_ctrl_entry.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dti_pr_entry : per-TBU connection/reset FSM with pending flag and ACK timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module dti_pr_entry
    import dti_pr_ctrl_pkg::*;
#(
    parameter int TO_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pr_req,
    input  logic [TO_W-1:0] to_limit,
    input  logic            beat_acc,
    input  logic            beat_last,
    input  logic            ack_acc,
    input  logic            ack_state,
    input  logic            inj_acc,
    output logic            pr_done,
    output logic            pr_err,
    output logic            tbu_idle,
    output logic            in_reset,
    output logic            inj_req,
    output logic            inj_flush
);

    pr_state_e       state_q, state_d;
    logic            pend_q, pend_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0] cnt_inc;
    logic            done_q, done_d;
    logic            err_q, err_d;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (pr_req) begin
            err_d = 1'b0;
        end
        case (state_q)
            PR_IDLE: begin
                done_d = pr_req;
                if (ack_acc && ack_state) begin
                    state_d = PR_CONN;
                end
            end
            PR_CONN: begin
                if (pend_q) begin
                    state_d = PR_DREQ;
                end else if (ack_acc && !ack_state) begin
                    state_d = PR_IDLE;
                end else if (beat_acc && !beat_last) begin
                    state_d = PR_TRANS;
                end
            end
            PR_TRANS: begin
                if (pend_q) begin
                    state_d = PR_FLUSH;
                end else if (beat_acc && beat_last) begin
                    state_d = PR_CONN;
                end
            end
            PR_FLUSH: begin
                if (inj_acc) begin
                    state_d = PR_DREQ;
                end
            end
            PR_DREQ: begin
                if (inj_acc) begin
                    state_d = PR_DWAIT;
                    cnt_d   = '0;
                end
            end
            PR_DWAIT: begin
                cnt_d = cnt_inc;
                // The ACK wins over a coincident timeout; the limit is hit once the count reaches it
                if (ack_acc && !ack_state) begin
                    state_d = PR_IDLE;
                    done_d  = 1'b1;
                end else if ((to_limit != '0) && (cnt_inc == to_limit)) begin
                    state_d = PR_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = PR_IDLE;
        endcase

        pend_d = 1'b0;
        if (((state_q == PR_CONN) || (state_q == PR_TRANS)) &&
            ((state_d == PR_CONN) || (state_d == PR_TRANS))) begin
            pend_d = pend_q | pr_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PR_IDLE;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pr_done   = done_q;
    assign pr_err    = err_q;
    assign tbu_idle  = (state_q == PR_IDLE);
    assign inj_flush = (state_q == PR_FLUSH);
    assign inj_req   = (state_q == PR_FLUSH) || (state_q == PR_DREQ);
    assign in_reset  = inj_req || (state_q == PR_DWAIT);

endmodule
`default_nettype wire

// File: rtl/dti_pr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dti_pr_ctrl : per-TBU partial-reset controller between DTI AXI-Stream and NoC
// Rev 1.0
// ----------------------------------------------------------------------------
module dti_pr_ctrl
    import dti_pr_ctrl_pkg::*;
#(
    parameter int TBU_NUM = 8,
    parameter int ID_W    = 6,
    parameter int DATA_W  = 80,
    parameter int TO_W    = 12,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TBU_NUM-1:0]       pr_req,
    output logic [TBU_NUM-1:0]       pr_done,
    output logic [TBU_NUM-1:0]       pr_err,
    output logic [TBU_NUM-1:0]       tbu_idle,
    output logic                     idle,
    input  logic [TO_W-1:0]          to_limit,
    input  logic                     req_tvalid,
    input  logic [DATA_W-1:0]        req_tdata,
    input  logic [KEEP_W-1:0]        req_tkeep,
    input  logic                     req_tlast,
    input  logic [ID_W-1:0]          req_tid,
    output logic                     req_tready,
    output logic                     rsp_tvalid,
    output logic [DATA_W-1:0]        rsp_tdata,
    output logic [KEEP_W-1:0]        rsp_tkeep,
    output logic                     rsp_tlast,
    output logic [ID_W-1:0]          rsp_tid,
    input  logic                     rsp_tready,
    output logic                     req_valid,
    output logic [DATA_W+KEEP_W-1:0] req_payload,
    output logic [ID_W-1:0]          req_srcid,
    output logic [ID_W-1:0]          req_tgtid,
    output logic                     req_qos,
    output logic                     req_last,
    input  logic                     req_ready,
    input  logic                     req_threshold,
    input  logic                     rsp_valid,
    input  logic [DATA_W+KEEP_W-1:0] rsp_payload,
    input  logic [ID_W-1:0]          rsp_srcid,
    input  logic [ID_W-1:0]          rsp_tgtid,
    input  logic                     rsp_qos,
    input  logic                     rsp_last,
    output logic                     rsp_ready,
    output logic                     rsp_threshold
);

    localparam int IDX_W   = (TBU_NUM > 1) ? $clog2(TBU_NUM) : 1;
    localparam int MSG_LSB = msg_type_lsb(KEEP_W);
    localparam int ST_BIT  = state_bit_pos(KEEP_W);
    localparam logic [KEEP_W-1:0] CONDIS_KEEP = KEEP_W'(4'hf);

    logic [TBU_NUM-1:0] w_tid_hit, w_rsp_hit, w_up_hit, w_gnt_oh;
    logic [TBU_NUM-1:0] w_in_rst, w_inj_req, w_inj_flush;
    logic               w_tid_drop, w_rsp_drop, w_up_rst, w_up_blk;
    logic               w_inj_sel, w_inj_acc, w_pt_acc, w_gnt_flush;
    logic               w_ack, w_ack_state;
    logic [3:0]         w_msg;
    logic [IDX_W-1:0]   w_pick, w_scan, w_gnt;
    logic               w_unused;

    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               hold_q, hold_d;
    logic [IDX_W-1:0]   hold_idx_q, hold_idx_d;
    logic               up_open_q, up_open_d;
    logic [ID_W-1:0]    up_tid_q, up_tid_d;

    assign w_unused = ^{req_threshold, rsp_srcid, rsp_qos};

    assign w_msg       = rsp_payload[MSG_LSB+3:MSG_LSB];
    assign w_ack_state = rsp_payload[ST_BIT];
    assign w_ack       = rsp_valid && rsp_ready && (w_msg == DTI_TBU_CONDIS_ACK);

    generate
        for (genvar i = 0; i < TBU_NUM; i++) begin : g_entry
            assign w_tid_hit[i] = (req_tid == ID_W'(i));
            assign w_rsp_hit[i] = (rsp_tgtid == ID_W'(i));
            assign w_up_hit[i]  = (up_tid_q == ID_W'(i));
            assign w_gnt_oh[i]  = (w_gnt == IDX_W'(i));

            dti_pr_entry #(
                .TO_W (TO_W)
            ) u_entry (
                .clk       (clk),
                .rst_n     (rst_n),
                .pr_req    (pr_req[i]),
                .to_limit  (to_limit),
                .beat_acc  (w_pt_acc && w_tid_hit[i]),
                .beat_last (req_tlast),
                .ack_acc   (w_ack && w_rsp_hit[i]),
                .ack_state (w_ack_state),
                .inj_acc   (w_inj_acc && w_gnt_oh[i]),
                .pr_done   (pr_done[i]),
                .pr_err    (pr_err[i]),
                .tbu_idle  (tbu_idle[i]),
                .in_reset  (w_in_rst[i]),
                .inj_req   (w_inj_req[i]),
                .inj_flush (w_inj_flush[i])
            );
        end
    endgenerate

    assign idle = &tbu_idle;

    // Round-robin scan starting at the pointer; lowest offset wins
    always_comb begin
        w_pick = '0;
        w_scan = '0;
        for (int k = TBU_NUM - 1; k >= 0; k--) begin
            w_scan = IDX_W'((int'(rr_q) + k) % TBU_NUM);
            if (w_inj_req[w_scan]) begin
                w_pick = w_scan;
            end
        end
    end

    assign w_gnt       = hold_q ? hold_idx_q : w_pick;
    assign w_gnt_flush = |(w_gnt_oh & w_inj_flush);

    // A packet already open for a TBU that is not being reset must finish first
    assign w_tid_drop = |(w_tid_hit & w_in_rst);
    assign w_rsp_drop = |(w_rsp_hit & w_in_rst);
    assign w_up_rst   = |(w_up_hit & w_in_rst);
    assign w_up_blk   = up_open_q && !w_up_rst;
    assign w_inj_sel  = (|w_inj_req) && !w_up_blk;
    assign w_inj_acc  = w_inj_sel && req_ready;
    assign w_pt_acc   = !w_inj_sel && req_tvalid && !w_tid_drop && req_ready;

    assign req_valid   = w_inj_sel || (req_tvalid && !w_tid_drop);
    assign req_payload = w_inj_sel ? {{DATA_W{1'b0}}, (w_gnt_flush ? {KEEP_W{1'b1}} : CONDIS_KEEP)}
                                   : {req_tdata, req_tkeep};
    assign req_srcid   = w_inj_sel ? ID_W'(w_gnt) : req_tid;
    assign req_last    = w_inj_sel || req_tlast;
    assign req_tgtid   = '0;
    assign req_qos     = 1'b1;
    assign req_tready  = w_tid_drop || (!w_inj_sel && req_ready);

    assign rsp_tvalid    = rsp_valid && !w_rsp_drop;
    assign rsp_tdata     = rsp_payload[DATA_W+KEEP_W-1:KEEP_W];
    assign rsp_tkeep     = rsp_payload[KEEP_W-1:0];
    assign rsp_tlast     = rsp_last;
    assign rsp_tid       = rsp_tgtid;
    assign rsp_ready     = w_rsp_drop || rsp_tready;
    assign rsp_threshold = 1'b1;

    always_comb begin
        rr_d       = rr_q;
        hold_d     = w_inj_sel && !req_ready;
        hold_idx_d = hold_idx_q;
        up_open_d  = up_open_q;
        up_tid_d   = up_tid_q;
        if (w_inj_acc) begin
            rr_d = (w_gnt == IDX_W'(TBU_NUM - 1)) ? '0 : w_gnt + 1'b1;
        end
        if (w_inj_sel && !req_ready) begin
            hold_idx_d = w_gnt;
        end
        if (w_pt_acc) begin
            up_open_d = !req_tlast;
            up_tid_d  = req_tid;
        end else if (up_open_q && w_up_rst) begin
            up_open_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            up_open_q  <= 1'b0;
            up_tid_q   <= '0;
        end else begin
            rr_q       <= rr_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
            up_open_q  <= up_open_d;
            up_tid_q   <= up_tid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dti_pr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dti_pr_ctrl : directed self-checking bench for dti_pr_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dti_pr_ctrl;

    localparam int TBU_NUM = 8;
    localparam int ID_W    = 6;
    localparam int DATA_W  = 80;
    localparam int KEEP_W  = 10;
    localparam int TO_W    = 12;
    localparam int PL_W    = DATA_W + KEEP_W;
    localparam logic [PL_W-1:0] CLOSE_PL = 90'h3ff;
    localparam logic [PL_W-1:0] DREQ_PL  = 90'h00f;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [TBU_NUM-1:0] pr_req, pr_done, pr_err, tbu_idle;
    logic               idle;
    logic [TO_W-1:0]    to_limit;
    logic               req_tvalid, req_tlast, req_tready;
    logic [DATA_W-1:0]  req_tdata, rsp_tdata;
    logic [KEEP_W-1:0]  req_tkeep, rsp_tkeep;
    logic [ID_W-1:0]    req_tid, rsp_tid;
    logic               rsp_tvalid, rsp_tlast, rsp_tready;
    logic               req_valid, req_qos, req_last, req_ready, req_threshold;
    logic [PL_W-1:0]    req_payload, rsp_payload;
    logic [ID_W-1:0]    req_srcid, req_tgtid, rsp_srcid, rsp_tgtid;
    logic               rsp_valid, rsp_qos, rsp_last, rsp_ready, rsp_threshold;

    int n_chk  = 0;
    int n_fail = 0;

    dti_pr_ctrl #(
        .TBU_NUM (TBU_NUM),
        .ID_W    (ID_W),
        .DATA_W  (DATA_W),
        .TO_W    (TO_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pr_req        (pr_req),
        .pr_done       (pr_done),
        .pr_err        (pr_err),
        .tbu_idle      (tbu_idle),
        .idle          (idle),
        .to_limit      (to_limit),
        .req_tvalid    (req_tvalid),
        .req_tdata     (req_tdata),
        .req_tkeep     (req_tkeep),
        .req_tlast     (req_tlast),
        .req_tid       (req_tid),
        .req_tready    (req_tready),
        .rsp_tvalid    (rsp_tvalid),
        .rsp_tdata     (rsp_tdata),
        .rsp_tkeep     (rsp_tkeep),
        .rsp_tlast     (rsp_tlast),
        .rsp_tid       (rsp_tid),
        .rsp_tready    (rsp_tready),
        .req_valid     (req_valid),
        .req_payload   (req_payload),
        .req_srcid     (req_srcid),
        .req_tgtid     (req_tgtid),
        .req_qos       (req_qos),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .req_threshold (req_threshold),
        .rsp_valid     (rsp_valid),
        .rsp_payload   (rsp_payload),
        .rsp_srcid     (rsp_srcid),
        .rsp_tgtid     (rsp_tgtid),
        .rsp_qos       (rsp_qos),
        .rsp_last      (rsp_last),
        .rsp_ready     (rsp_ready),
        .rsp_threshold (rsp_threshold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rsp(input int id, input logic [PL_W-1:0] pl);
        rsp_valid   = 1'b1;
        rsp_tgtid   = ID_W'(id);
        rsp_srcid   = ID_W'(id);
        rsp_payload = pl;
        rsp_last    = 1'b1;
    endtask

    // ACK payload: msg_type 0 in tdata[3:0], state in tdata[4]
    task automatic send_ack(input int id, input logic st);
        logic [PL_W-1:0] pl;
        pl = '0;
        pl[KEEP_W+4] = st;
        set_rsp(id, pl);
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic up_beat(input int tid, input logic [DATA_W-1:0] d, input logic last);
        req_tvalid = 1'b1;
        req_tid    = ID_W'(tid);
        req_tdata  = d;
        req_tkeep  = '1;
        req_tlast  = last;
    endtask

    initial begin
        rst_n = 1'b0; pr_req = '0; to_limit = '0;
        req_tvalid = 1'b0; req_tdata = '0; req_tkeep = '0; req_tlast = 1'b0; req_tid = '0;
        rsp_tready = 1'b1; req_ready = 1'b1; req_threshold = 1'b0;
        rsp_valid = 1'b0; rsp_payload = '0; rsp_srcid = '0; rsp_tgtid = '0; rsp_qos = 1'b0; rsp_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tbu_idle", tbu_idle, 8'hff);
        chk("rst_idle", idle, 1'b1);
        chk("rst_pr_done", pr_done, 8'h00);
        chk("rst_pr_err", pr_err, 8'h00);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_rsp_tvalid", rsp_tvalid, 1'b0);
        chk("req_tgtid", req_tgtid, 6'd0);
        chk("req_qos", req_qos, 1'b1);
        rst_n = 1'b1;
        tick();

        // Connect / disconnect TBU 3
        set_rsp(3, 90'h4000);
        #1;
        chk("ack_fwd_valid", rsp_tvalid, 1'b1);
        chk("ack_fwd_tid", rsp_tid, 6'd3);
        tick();
        rsp_valid = 1'b0;
        chk("conn3_tbu_idle", tbu_idle, 8'hf7);
        chk("conn3_idle", idle, 1'b0);
        send_ack(3, 1'b0);
        chk("disc3_tbu_idle", tbu_idle, 8'hff);

        // TBU 2 reset in the middle of a 4-beat packet
        send_ack(2, 1'b1);
        up_beat(2, 80'hA1, 1'b0);
        #1;
        chk("t2_b1_valid", req_valid, 1'b1);
        chk("t2_b1_payload", req_payload, {80'hA1, 10'h3ff});
        tick();
        up_beat(2, 80'hA2, 1'b0);
        tick();
        req_tvalid = 1'b0;
        pr_req = 8'h04;
        tick();
        pr_req = '0;
        #1;
        chk("t2_pend_no_inj", req_valid, 1'b0);
        tick();
        chk("t2_close_valid", req_valid, 1'b1);
        chk("t2_close_srcid", req_srcid, 6'd2);
        chk("t2_close_last", req_last, 1'b1);
        chk("t2_close_payload", req_payload, CLOSE_PL);
        tick();
        chk("t2_dreq_payload", req_payload, DREQ_PL);
        chk("t2_dreq_srcid", req_srcid, 6'd2);
        tick();
        up_beat(2, 80'hA3, 1'b0);
        #1;
        chk("t2_drop_tready", req_tready, 1'b1);
        chk("t2_drop_valid", req_valid, 1'b0);
        tick();
        up_beat(2, 80'hA4, 1'b1);
        tick();
        req_tvalid = 1'b0;
        rsp_tready = 1'b0;
        set_rsp(2, 90'h0);
        #1;
        chk("t2_ack_consumed_tvalid", rsp_tvalid, 1'b0);
        chk("t2_ack_consumed_ready", rsp_ready, 1'b1);
        tick();
        rsp_valid = 1'b0;
        rsp_tready = 1'b1;
        chk("t2_pr_done", pr_done, 8'h04);
        chk("t2_tbu_idle", tbu_idle, 8'hff);
        tick();
        chk("t2_pr_done_pulse", pr_done, 8'h00);

        // Fresh reset, then multi-TBU reset with TBU 5 traffic
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_ack(1, 1'b1);
        send_ack(4, 1'b1);
        send_ack(5, 1'b1);
        send_ack(6, 1'b1);
        pr_req = 8'b0101_0010;
        up_beat(5, 80'hB1, 1'b0);
        #1;
        chk("t3_b1_srcid", req_srcid, 6'd5);
        tick();
        pr_req = '0;
        up_beat(5, 80'hB2, 1'b1);
        #1;
        chk("t3_b2_srcid", req_srcid, 6'd5);
        chk("t3_b2_last", req_last, 1'b1);
        tick();
        up_beat(5, 80'hB3, 1'b1);
        #1;
        chk("t3_inj0_srcid", req_srcid, 6'd1);
        chk("t3_inj0_payload", req_payload, DREQ_PL);
        chk("t3_up_stalled", req_tready, 1'b0);
        tick();
        chk("t3_inj1_srcid", req_srcid, 6'd4);
        tick();
        chk("t3_inj2_srcid", req_srcid, 6'd6);
        tick();
        chk("t3_b3_srcid", req_srcid, 6'd5);
        chk("t3_b3_payload", req_payload, {80'hB3, 10'h3ff});
        tick();
        req_tvalid = 1'b0;
        send_ack(1, 1'b0);
        chk("t3_done1", pr_done, 8'h02);
        send_ack(4, 1'b0);
        chk("t3_done4", pr_done, 8'h10);
        send_ack(6, 1'b0);
        chk("t3_done6", pr_done, 8'h40);
        chk("t3_tbu_idle", tbu_idle, 8'hdf);

        // ACK timeout on TBU 0
        send_ack(0, 1'b1);
        to_limit = 12'd16;
        pr_req = 8'h01;
        tick();
        pr_req = '0;
        tick();
        chk("t4_dreq_srcid", req_srcid, 6'd0);
        tick();
        repeat (15) tick();
        chk("t4_no_err_yet", pr_err, 8'h00);
        tick();
        chk("t4_err", pr_err, 8'h01);
        chk("t4_tbu_idle", tbu_idle, 8'hdf);
        pr_req = 8'h01;
        tick();
        pr_req = '0;
        chk("t4_err_cleared", pr_err, 8'h00);
        chk("t4_idle_done", pr_done, 8'h01);

        // Back-pressure during injection keeps the grant stable
        to_limit = '0;
        send_ack(7, 1'b1);
        send_ack(3, 1'b1);
        pr_req = 8'h80;
        tick();
        pr_req = '0;
        tick();
        req_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("t5_hold_srcid", req_srcid, 6'd7);
            chk("t5_hold_payload", req_payload, DREQ_PL);
            chk("t5_hold_valid", req_valid, 1'b1);
            if (s == 0) pr_req = 8'h08;
            tick();
            pr_req = '0;
        end
        req_ready = 1'b1;
        #1;
        chk("t5_rel_srcid", req_srcid, 6'd7);
        tick();
        chk("t5_next_srcid", req_srcid, 6'd3);
        tick();
        rsp_tready = 1'b0;
        set_rsp(7, 90'h400);
        #1;
        chk("t5_rst_rsp_tvalid", rsp_tvalid, 1'b0);
        chk("t5_rst_rsp_ready", rsp_ready, 1'b1);
        set_rsp(5, {80'hBEEF, 10'h155});
        #1;
        chk("t5_fwd_tvalid", rsp_tvalid, 1'b1);
        chk("t5_fwd_ready", rsp_ready, 1'b0);
        chk("t5_fwd_tdata", rsp_tdata, 80'hBEEF);
        chk("t5_fwd_tkeep", rsp_tkeep, 10'h155);
        chk("t5_fwd_tid", rsp_tid, 6'd5);
        rsp_valid = 1'b0;
        rsp_tready = 1'b1;
        tick();

        // Asynchronous reset while TBUs 3 and 7 wait for their ACK
        chk("t6_pre_tbu_idle", tbu_idle, 8'h57);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_tbu_idle", tbu_idle, 8'hff);
        chk("t6_idle", idle, 1'b1);
        chk("t6_req_valid", req_valid, 1'b0);
        chk("t6_rsp_tvalid", rsp_tvalid, 1'b0);
        chk("t6_pr_err", pr_err, 8'h00);
        chk("t6_pr_done", pr_done, 8'h00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_post_req_valid", req_valid, 1'b0);
        tick();
        chk("t6_post2_req_valid", req_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
